fnn_param_loader: RTL and testbench

Configuration-bus transmitter for the FNN accelerator. Accepts a host word stream of headers and payloads and drives the broadcast weight/bias load bus (weightValid, biasValid, weightValue, biasValue, config_layer_num, config_neuron_num). Every neuron listens on this bus and captures only words addressed to its layer and neuron. Sits between the host DMA/stream interface and all layer instances. It is active only during load, before inference.

---
 rtl/fnn_cfg_pkg.sv | 64 ++++++
 rtl/fnn_param_loader.sv | 150 +++++++++++++++
 tb/tb_fnn_param_loader.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fnn_cfg_pkg.sv
// Shared types and header decode for the FNN configuration-bus loader.
// CHK state exists only when FNN_LOADER_CHECKSUM_EN is defined.
package fnn_cfg_pkg;

    typedef enum logic [1:0] {
        KIND_ILL  = 2'b00,
        KIND_WGT  = 2'b01,
        KIND_BIAS = 2'b10,
        KIND_TERM = 2'b11
    } kind_e;

    localparam int HDR_KIND_MSB   = 31;
    localparam int HDR_KIND_LSB   = 30;
    localparam int HDR_LAYER_MSB  = 29;
    localparam int HDR_LAYER_LSB  = 22;
    localparam int HDR_NEURON_MSB = 21;
    localparam int HDR_NEURON_LSB = 12;
    localparam int HDR_COUNT_MSB  = 11;
    localparam int HDR_COUNT_LSB  = 0;

    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_WGT   = 3'd1,
        ST_BIAS  = 3'd2,
        ST_DRAIN = 3'd3,
`ifdef FNN_LOADER_CHECKSUM_EN
        ST_CHK   = 3'd4,
`endif
        ST_DONE  = 3'd5
    } loader_state_e;

    typedef struct packed {
        kind_e kind;
        logic  legal;
    } hdr_dec_t;

    // Terminators are always legal; weight/bias need an addressable neuron and a sane count.
    function automatic hdr_dec_t decode_hdr(
        input logic [31:0] hdr,
        input int          numLayers,
        input int          maxNeurons,
        input int          maxWeights
    );
        hdr_dec_t    dec;
        logic [31:0] layer;
        logic [31:0] neuron;
        logic [31:0] count;
        logic        addrOk;
        dec.kind = kind_e'(hdr[HDR_KIND_MSB:HDR_KIND_LSB]);
        layer    = 32'(hdr[HDR_LAYER_MSB:HDR_LAYER_LSB]);
        neuron   = 32'(hdr[HDR_NEURON_MSB:HDR_NEURON_LSB]);
        count    = 32'(hdr[HDR_COUNT_MSB:HDR_COUNT_LSB]);
        addrOk   = (layer >= 32'd1) && (layer <= $unsigned(numLayers))
                   && (neuron <= $unsigned(maxNeurons));
        case (dec.kind)
            KIND_WGT:  dec.legal = addrOk && (count >= 32'd1) && (count <= $unsigned(maxWeights));
            KIND_BIAS: dec.legal = addrOk && (count == 32'd1);
            KIND_TERM: dec.legal = 1'b1;
            default:   dec.legal = 1'b0;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/fnn_param_loader.sv
// Host-stream to weight/bias broadcast-bus transmitter for the FNN accelerator.
// Optional checksum stage enabled by FNN_LOADER_CHECKSUM_EN.
module fnn_param_loader
    import fnn_cfg_pkg::*;
#(
    parameter int NUM_LAYERS  = 4,
    parameter int MAX_NEURONS = 1023,
    parameter int MAX_WEIGHTS = 784
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        weightValid,
    output logic        biasValid,
    output logic [31:0] weightValue,
    output logic [31:0] biasValue,
    output logic [31:0] config_layer_num,
    output logic [31:0] config_neuron_num,
    output logic        load_done,
    output logic        hdr_err,
    output logic        chk_err
);

    loader_state_e r_state;
    loader_state_e w_nextState;
    logic [11:0]   r_count;
    logic [11:0]   w_nextCount;
    logic [11:0]   w_hdrCount;
    hdr_dec_t      w_dec;
    logic          w_beat;
    logic          w_loadCfg;
    logic          w_wgtStrobe;
    logic          w_biasStrobe;
    logic          w_hdrErr;
`ifdef FNN_LOADER_CHECKSUM_EN
    logic          w_chkBeat;
    logic [31:0]   r_sum;
`endif

    assign w_beat     = s_valid & s_ready;
    assign w_hdrCount = s_data[HDR_COUNT_MSB:HDR_COUNT_LSB];
    assign w_dec      = decode_hdr(s_data, NUM_LAYERS, MAX_NEURONS, MAX_WEIGHTS);

    always_comb begin
        w_nextState  = r_state;
        w_nextCount  = r_count;
        w_loadCfg    = 1'b0;
        w_wgtStrobe  = 1'b0;
        w_biasStrobe = 1'b0;
        w_hdrErr     = 1'b0;
`ifdef FNN_LOADER_CHECKSUM_EN
        w_chkBeat    = 1'b0;
`endif
        if (w_beat) begin
            case (r_state)
                ST_HDR: begin
                    if (w_dec.legal && (w_dec.kind == KIND_WGT)) begin
                        w_nextState = ST_WGT;
                        w_nextCount = w_hdrCount;
                        w_loadCfg   = 1'b1;
                    end else if (w_dec.legal && (w_dec.kind == KIND_BIAS)) begin
                        w_nextState = ST_BIAS;
                        w_loadCfg   = 1'b1;
                    end else if (w_dec.legal && (w_dec.kind == KIND_TERM)) begin
`ifdef FNN_LOADER_CHECKSUM_EN
                        w_nextState = ST_CHK;
`else
                        w_nextState = ST_DONE;
`endif
                    end else begin
                        // Illegal header: swallow its payload so the stream stays framed.
                        w_hdrErr    = 1'b1;
                        w_nextCount = w_hdrCount;
                        w_nextState = (w_hdrCount != 12'd0) ? ST_DRAIN : ST_HDR;
                    end
                end
                ST_WGT: begin
                    w_wgtStrobe = 1'b1;
                    w_nextCount = (r_count != 12'd0) ? r_count - 12'd1 : 12'd0;
                    if (r_count <= 12'd1) w_nextState = ST_HDR;
                end
                ST_BIAS: begin
                    w_biasStrobe = 1'b1;
                    w_nextState  = ST_HDR;
                end
                ST_DRAIN: begin
                    w_nextCount = (r_count != 12'd0) ? r_count - 12'd1 : 12'd0;
                    if (r_count <= 12'd1) w_nextState = ST_HDR;
                end
`ifdef FNN_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    w_chkBeat   = 1'b1;
                    w_nextState = ST_DONE;
                end
`endif
                ST_DONE: w_nextState = ST_DONE;
                default: w_nextState = ST_HDR;
            endcase
        end
    end

    // s_ready and load_done follow the next state so DONE takes effect right after the terminator.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= ST_HDR;
            r_count           <= 12'd0;
            s_ready           <= 1'b0;
            load_done         <= 1'b0;
            weightValid       <= 1'b0;
            biasValid         <= 1'b0;
            weightValue       <= 32'd0;
            biasValue         <= 32'd0;
            config_layer_num  <= 32'd0;
            config_neuron_num <= 32'd0;
            hdr_err           <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_count     <= w_nextCount;
            s_ready     <= (w_nextState != ST_DONE);
            load_done   <= (w_nextState == ST_DONE);
            weightValid <= w_wgtStrobe;
            biasValid   <= w_biasStrobe;
            hdr_err     <= hdr_err | w_hdrErr;
            if (w_wgtStrobe)  weightValue <= s_data;
            if (w_biasStrobe) biasValue   <= s_data;
            if (w_loadCfg) begin
                config_layer_num  <= 32'(s_data[HDR_LAYER_MSB:HDR_LAYER_LSB]);
                config_neuron_num <= 32'(s_data[HDR_NEURON_MSB:HDR_NEURON_LSB]);
            end
        end
    end

`ifdef FNN_LOADER_CHECKSUM_EN
    // Running 32-bit wrapping sum of every payload actually put on the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum   <= 32'd0;
            chk_err <= 1'b0;
        end else begin
            if (w_wgtStrobe || w_biasStrobe) r_sum <= r_sum + s_data;
            if (w_chkBeat && (s_data != r_sum)) chk_err <= 1'b1;
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_fnn_param_loader.sv
// Self-checking bench for fnn_param_loader against a record-level stream model.
// Honours FNN_LOADER_CHECKSUM_EN the same way as the design.
module tb_fnn_param_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_data = 32'd0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        weightValid;
    logic        biasValid;
    logic [31:0] weightValue;
    logic [31:0] biasValue;
    logic [31:0] config_layer_num;
    logic [31:0] config_neuron_num;
    logic        load_done;
    logic        hdr_err;
    logic        chk_err;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [31:0] words[$];
    int          role[$];
    int          roleLayer[$];
    int          roleNeuron[$];
    int          nAccept;
    bit          expHdrErr;
    bit          expDone;
    bit          expChk;
    logic [31:0] sumGen;

    always #5 clk = ~clk;

    fnn_param_loader dut (
        .clk               (clk),
        .rst               (rst),
        .s_data            (s_data),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .weightValid       (weightValid),
        .biasValid         (biasValid),
        .weightValue       (weightValue),
        .biasValue         (biasValue),
        .config_layer_num  (config_layer_num),
        .config_neuron_num (config_neuron_num),
        .load_done         (load_done),
        .hdr_err           (hdr_err),
        .chk_err           (chk_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mkHdr(input int kind, input int layer, input int neuron, input int count);
        return {kind[1:0], layer[7:0], neuron[9:0], count[11:0]};
    endfunction

    // Record-level parse of the word list: which words become strobes, and the final flags.
    task automatic buildModel();
        int          i;
        int          kind, layer, neuron, cnt;
        bit          addrOk;
        logic [31:0] h;
        logic [31:0] sum;
        role.delete(); roleLayer.delete(); roleNeuron.delete();
        foreach (words[k]) begin
            role.push_back(0); roleLayer.push_back(0); roleNeuron.push_back(0);
        end
        expHdrErr = 0; expDone = 0; expChk = 0; sum = 32'd0; i = 0;
        nAccept = words.size();
        while (i < words.size()) begin
            h      = words[i];
            kind   = int'(h[31:30]);
            layer  = int'(h[29:22]);
            neuron = int'(h[21:12]);
            cnt    = int'(h[11:0]);
            i++;
            addrOk = (layer >= 1) && (layer <= 4) && (neuron <= 1023);
            if (kind == 1 && addrOk && cnt >= 1 && cnt <= 784) begin
                for (int j = 0; j < cnt && i < words.size(); j++) begin
                    role[i] = 1; roleLayer[i] = layer; roleNeuron[i] = neuron;
                    sum += words[i]; i++;
                end
            end else if (kind == 2 && addrOk && cnt == 1) begin
                if (i < words.size()) begin
                    role[i] = 2; roleLayer[i] = layer; roleNeuron[i] = neuron;
                    sum += words[i]; i++;
                end
            end else if (kind == 3) begin
                expDone = 1;
`ifdef FNN_LOADER_CHECKSUM_EN
                if (i < words.size()) begin
                    expChk = (words[i] != sum);
                    i++;
                end
`endif
                nAccept = i;
                break;
            end else begin
                expHdrErr = 1;
                i += cnt;
                if (i > words.size()) i = words.size();
            end
        end
    endtask

    task automatic checkStrobe(input int acc);
        int kind;
        kind = (acc >= 0) ? role[acc] : 0;
        checkOutput("weightValid", 32'(weightValid), 32'(kind == 1));
        checkOutput("biasValid", 32'(biasValid), 32'(kind == 2));
        if (kind == 1) checkOutput("weightValue", weightValue, words[acc]);
        if (kind == 2) checkOutput("biasValue", biasValue, words[acc]);
        if (kind != 0) begin
            checkOutput("config_layer", config_layer_num, 32'(roleLayer[acc]));
            checkOutput("config_neuron", config_neuron_num, 32'(roleNeuron[acc]));
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
        checkOutput("rst_strobes", 32'({weightValid, biasValid}), 32'd0);
        checkOutput("rst_values", weightValue | biasValue, 32'd0);
        checkOutput("rst_config", config_layer_num | config_neuron_num, 32'd0);
        checkOutput("rst_flags", 32'({load_done, hdr_err, chk_err}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_s_ready", 32'(s_ready), 32'd1);
    endtask

    // mode 0: valid every cycle, 1: every other cycle, 2: random gaps.
    task automatic applyStimulus(input int mode);
        int idx = 0;
        int lastAcc = -1;
        int cycles = 0;
        bit drive;
        buildModel();
        while (idx < nAccept || lastAcc >= 0) begin
            @(negedge clk);
            cycles++;
            if (cycles > 5000) begin
                checkOutput("stream_timeout", 32'(idx), 32'(nAccept));
                s_valid = 1'b0;
                return;
            end
            checkStrobe(lastAcc);
            lastAcc = -1;
            if (idx < nAccept) begin
                checkOutput("s_ready", 32'(s_ready), 32'd1);
                drive = (mode == 0) || (mode == 1 && cycles % 2 == 0)
                        || (mode == 2 && $urandom_range(3) != 0);
                if (drive) begin
                    s_valid = 1'b1; s_data = words[idx];
                    lastAcc = idx; idx++;
                end else begin
                    s_valid = 1'b0; s_data = $urandom;
                end
            end else begin
                s_valid = 1'b0;
            end
        end
        for (int k = nAccept; k < words.size(); k++) begin
            @(negedge clk);
            checkStrobe(-1);
            checkOutput("done_s_ready", 32'(s_ready), 32'd0);
            checkOutput("done_load_done", 32'(load_done), 32'd1);
            s_valid = 1'b1; s_data = words[k];
        end
        @(negedge clk);
        s_valid = 1'b0;
        checkStrobe(-1);
        checkOutput("hdr_err", 32'(hdr_err), 32'(expHdrErr));
        checkOutput("load_done", 32'(load_done), 32'(expDone));
        checkOutput("chk_err", 32'(chk_err), 32'(expChk));
    endtask

    task automatic addWeight(input int layer, input int neuron, input int cnt);
        logic [31:0] v;
        words.push_back(mkHdr(1, layer, neuron, cnt));
        for (int j = 0; j < cnt; j++) begin
            v = $urandom; words.push_back(v); sumGen += v;
        end
    endtask

    task automatic addBias(input int layer, input int neuron);
        logic [31:0] v;
        v = $urandom;
        words.push_back(mkHdr(2, layer, neuron, 1));
        words.push_back(v); sumGen += v;
    endtask

    task automatic addIllegal();
        int c;
        case ($urandom_range(4))
            0: begin c = $urandom_range(3); words.push_back(mkHdr(0, $urandom_range(4), 5, c)); end
            1: begin c = $urandom_range(1, 3); words.push_back(mkHdr(1, 0, 7, c)); end
            2: begin c = $urandom_range(1, 3); words.push_back(mkHdr(1, $urandom_range(5, 255), 9, c)); end
            3: begin c = 2; words.push_back(mkHdr(2, 1, 3, c)); end
            default: begin c = 0; words.push_back(mkHdr(1, 2, 4, c)); end
        endcase
        for (int j = 0; j < c; j++) words.push_back($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyReset();

        $display("[TB] weight record L1 N27 x3");
        words = '{mkHdr(1, 1, 27, 3), 32'h11, 32'h22, 32'h33};
        applyStimulus(0);

        $display("[TB] bias record L2 N0");
        applyReset();
        words = '{mkHdr(2, 2, 0, 1), 32'h8BC};
        applyStimulus(0);

        $display("[TB] illegal header drained, then bias");
        applyReset();
        words = '{mkHdr(1, 0, 3, 2), 32'hAAAA, 32'hBBBB, mkHdr(2, 3, 9, 1), 32'h1234};
        applyStimulus(0);

        $display("[TB] weight x4 with alternating valid");
        applyReset();
        words = '{mkHdr(1, 4, 100, 4), 32'hA1, 32'hA2, 32'hA3, 32'hA4, mkHdr(2, 1, 1, 1), 32'hB0};
        applyStimulus(1);

        $display("[TB] count/layer/neuron boundaries");
        applyReset();
        words.delete(); sumGen = 32'd0;
        addWeight(4, 1023, 784);
        words.push_back(mkHdr(1, 1, 0, 785));
        for (int j = 0; j < 785; j++) words.push_back($urandom);
        words.push_back(mkHdr(2, 5, 0, 1)); words.push_back(32'hDEAD);
        addBias(1, 0);
        applyStimulus(0);

        for (int pass = 0; pass < 2; pass++) begin
            $display("[TB] terminator, checksum offset %0d", pass);
            applyReset();
            words.delete(); sumGen = 32'd0;
            addWeight(1, 1, 2);
            addBias(3, 44);
            words.push_back(mkHdr(3, 0, 0, 0));
`ifdef FNN_LOADER_CHECKSUM_EN
            words.push_back(sumGen + 32'(pass));
`endif
            words.push_back($urandom); words.push_back($urandom);
            applyStimulus(0);
        end

        $display("[TB] reset mid-record");
        applyReset();
        words = '{mkHdr(1, 2, 5, 5), 32'hC1, 32'hC2};
        applyStimulus(0);
        rst = 1'b1; s_valid = 1'b1; s_data = 32'hC3;
        @(negedge clk);
        checkOutput("midrst_strobes", 32'({weightValid, biasValid}), 32'd0);
        checkOutput("midrst_values", weightValue | biasValue, 32'd0);
        checkOutput("midrst_config", config_layer_num | config_neuron_num, 32'd0);
        checkOutput("midrst_ready", 32'(s_ready), 32'd0);
        rst = 1'b0; s_valid = 1'b0;
        words = '{mkHdr(2, 4, 600, 1), 32'h5555};
        applyStimulus(0);

        for (int it = 0; it < 5; it++) begin
            $display("[TB] random stream %0d", it);
            applyReset();
            words.delete(); sumGen = 32'd0;
            for (int r = 0; r < 8; r++) begin
                case ($urandom_range(9))
                    0, 1, 2, 3, 4, 8, 9: addWeight($urandom_range(1, 4), $urandom_range(1023), $urandom_range(1, 6));
                    5, 6: addBias($urandom_range(1, 4), $urandom_range(1023));
                    default: addIllegal();
                endcase
            end
            words.push_back(mkHdr(3, 0, 0, 0));
`ifdef FNN_LOADER_CHECKSUM_EN
            words.push_back(sumGen + 32'($urandom_range(1)));
`endif
            words.push_back($urandom);
            applyStimulus((it == 0) ? 0 : 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
